i2c_write_engine: RTL and testbench



---
 rtl/i2c_write_engine.sv | 163 ++++++++++++++++
 tb/tb_i2c_write_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_engine.sv
// I2C master write engine: sends START, {dev,W}, register, data, STOP with ACK
// checks after each byte, using open-drain enables driven from registers.
module i2c_write_engine #(
  parameter int QUARTER_DIV = 68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic       ack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int DIV_W = $clog2(QUARTER_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_DONE
  } state_t;

  state_t       state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [1:0]   q_reg, q_next;
  logic [4:0]   bit_reg, bit_next;
  logic [3:0]   pos_reg, pos_next;
  logic [23:0]  shift_reg, shift_next;
  logic         ack_err_reg, ack_err_next;
  logic         sda_meta_reg, sda_sync_reg;
  logic         scl_oe_reg, scl_oe_next;
  logic         sda_oe_reg, sda_oe_next;
  logic         tick;

  // Bus drive {scl_oe, sda_oe} for a given position in the transaction.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] q,
                                           logic ack_slot, logic bit_val);
    logic [1:0] r;
    r = 2'b00;
    case (st)
      S_START: begin
        case (q)
          2'd0:    r = 2'b00;
          2'd1:    r = 2'b01;
          default: r = 2'b11;
        endcase
      end
      S_BIT: r = {(q == 2'd0) || (q == 2'd3), ack_slot ? 1'b0 : ~bit_val};
      S_STOP: begin
        case (q)
          2'd0:    r = 2'b11;
          2'd1:    r = 2'b01;
          default: r = 2'b00;
        endcase
      end
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign tick = (div_reg == DIV_W'(QUARTER_DIV - 1));

  always_comb begin
    state_next   = state_reg;
    div_next     = tick ? '0 : div_reg + 1'b1;
    q_next       = tick ? q_reg + 2'd1 : q_reg;
    bit_next     = bit_reg;
    pos_next     = pos_reg;
    shift_next   = shift_reg;
    ack_err_next = ack_err_reg;
    case (state_reg)
      S_IDLE: begin
        div_next = '0;
        q_next   = 2'd0;
        if (cmd_valid) begin
          shift_next   = {cmd_dev_addr, 1'b0, cmd_reg_addr, cmd_data};
          ack_err_next = 1'b0;
          state_next   = S_START;
        end
      end
      S_START: begin
        if (tick && q_reg == 2'd2) begin
          state_next = S_BIT;
          q_next     = 2'd0;
          bit_next   = 5'd0;
          pos_next   = 4'd0;
        end
      end
      S_BIT: begin
        if (tick && q_reg == 2'd2 && pos_reg == 4'd8)
          ack_err_next = sda_sync_reg;
        if (tick && q_reg == 2'd3) begin
          if (pos_reg == 4'd8) begin
            // A NACK ends the transfer early; the remaining bytes are skipped.
            if (ack_err_reg || bit_reg == 5'd26) begin
              state_next = S_STOP;
            end else begin
              pos_next = 4'd0;
              bit_next = bit_reg + 5'd1;
            end
          end else begin
            shift_next = {shift_reg[22:0], 1'b0};
            pos_next   = pos_reg + 4'd1;
            bit_next   = bit_reg + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (tick && q_reg == 2'd3)
          state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Enables are registered from the next position so the pads never glitch.
    {scl_oe_next, sda_oe_next} = bus_drive(state_next, q_next, pos_next == 4'd8,
                                           shift_next[23]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      div_reg      <= '0;
      q_reg        <= 2'd0;
      bit_reg      <= 5'd0;
      pos_reg      <= 4'd0;
      shift_reg    <= '0;
      ack_err_reg  <= 1'b0;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      scl_oe_reg   <= 1'b0;
      sda_oe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      q_reg        <= q_next;
      bit_reg      <= bit_next;
      pos_reg      <= pos_next;
      shift_reg    <= shift_next;
      ack_err_reg  <= ack_err_next;
      sda_meta_reg <= sda_i;
      sda_sync_reg <= sda_meta_reg;
      scl_oe_reg   <= scl_oe_next;
      sda_oe_reg   <= sda_oe_next;
    end
  end

  assign cmd_ready = (state_reg == S_IDLE) && !rst;
  assign done      = (state_reg == S_DONE);
  assign busy      = (state_reg == S_START) || (state_reg == S_BIT) || (state_reg == S_STOP);
  assign ack_err   = ack_err_reg;
  assign scl_oe    = scl_oe_reg;
  assign sda_oe    = sda_oe_reg;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: quarter-level bus model, open-drain slave and
// bus decoder, per-cycle output comparison.
module tb_i2c_write_engine;
  localparam int Q = 4;

  logic       clk, rst, cmd_valid, cmd_ready, done, ack_err, busy;
  logic       scl_oe, sda_oe, sda_i;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr, cmd_data;
  logic       slave_pull = 1'b0;

  assign sda_i = ~(sda_oe | slave_pull);

  i2c_write_engine #(.QUARTER_DIV(Q)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .done(done), .ack_err(ack_err), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic scl; logic sda; logic done; logic busy; logic ready; logic chk_ack; logic ack;
  } exp_t;

  exp_t exp_q[$];
  int   exp_ev[$];
  int   got_ev[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0, last_done_cyc = -1, done_cnt = 0;
  bit   suspend = 1'b1;
  int   slave_nack = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, got, exp);
    end
  endtask

  // Model: each quarter holds its bus levels for Q cycles.
  task automatic push_quarter(input logic scl, input logic sda);
    exp_t e;
    e = '0; e.scl = scl; e.sda = sda; e.busy = 1'b1;
    repeat (Q) exp_q.push_back(e);
  endtask

  task automatic build_txn(input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] d, input int nack);
    logic [7:0] bytes [3];
    exp_t e;
    bytes[0] = {dev, 1'b0}; bytes[1] = ra; bytes[2] = d;
    e = '0; e.ready = 1'b1;
    exp_q.push_back(e);
    push_quarter(0, 0); push_quarter(0, 1); push_quarter(1, 1);
    exp_ev.push_back(256);
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i >= 0; i--) begin
        push_quarter(1, !bytes[b][i]); push_quarter(0, !bytes[b][i]);
        push_quarter(0, !bytes[b][i]); push_quarter(1, !bytes[b][i]);
      end
      push_quarter(1, 0); push_quarter(0, 0); push_quarter(0, 0); push_quarter(1, 0);
      exp_ev.push_back(int'(bytes[b]));
      if (b + 1 == nack) break;
    end
    push_quarter(1, 1); push_quarter(0, 1); push_quarter(0, 0); push_quarter(0, 0);
    exp_ev.push_back(512);
    e = '0; e.done = 1'b1; e.chk_ack = 1'b1; e.ack = (nack != 0);
    exp_q.push_back(e);
  endtask

  // Bus decoder and ACKing slave, on the wired-AND line levels.
  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         rise_cnt = 0, byte_idx = 0;
  logic [8:0] bus_sh = '0;
  always @(negedge clk) begin
    logic scl_l, sda_l;
    scl_l = ~scl_oe;
    sda_l = sda_i;
    if (scl_prev && scl_l && sda_prev && !sda_l) begin
      got_ev.push_back(256); rise_cnt = 0; byte_idx = 0;
    end else if (scl_prev && scl_l && !sda_prev && sda_l) begin
      got_ev.push_back(512); rise_cnt = 0;
    end else if (!scl_prev && scl_l) begin
      bus_sh = {bus_sh[7:0], sda_l};
      rise_cnt++;
      if (rise_cnt == 9) got_ev.push_back(int'(bus_sh[8:1]));
    end else if (scl_prev && !scl_l) begin
      if (rise_cnt == 8) slave_pull = (byte_idx + 1 != slave_nack);
      else if (rise_cnt == 9) begin
        slave_pull = 1'b0; rise_cnt = 0; byte_idx++;
      end
    end
    scl_prev = scl_l;
    sda_prev = sda_l;
  end

  // Per-cycle compare against the model; idle expectations when nothing is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (!suspend) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bus_cycle", {27'b0, scl_oe, sda_oe, done, busy, cmd_ready},
              {27'b0, e.scl, e.sda, e.done, e.busy, e.ready});
          if (e.chk_ack) chk("ack_err_at_done", {31'b0, ack_err}, {31'b0, e.ack});
        end else if (!rst) begin
          chk("idle", {27'b0, scl_oe, sda_oe, done, busy, cmd_ready}, 32'h1);
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_ev_count"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      chk({tag, "_ev"}, got_ev[i], exp_ev[i]);
  endtask

  task automatic randomize_payload();
    cmd_dev_addr = 7'($urandom);
    cmd_reg_addr = 8'($urandom);
    cmd_data     = 8'($urandom);
  endtask

  task automatic run_txn(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] d,
                         input int nack, input int lat, input string tag);
    int d0;
    @(posedge clk); #1;
    got_ev.delete(); exp_ev.delete();
    slave_nack = nack;
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_data = d;
    build_txn(dev, ra, d, nack);
    chk({tag, "_model_len"}, exp_q.size(), lat + 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    randomize_payload();
    wait_drain({tag, "_drain"});
    chk({tag, "_latency"}, last_done_cyc - acc_cyc, lat);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    check_events(tag);
    chk({tag, "_addr_byte"}, got_ev.size() > 1 ? got_ev[1] : -1, {24'h0, dev, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_ack_err_held"}, {31'b0, ack_err}, {31'b0, nack != 0});
    $display("[TB] txn %s dev=%02h reg=%02h data=%02h latency=%0d ack_err=%0b",
             tag, dev, ra, d, last_done_cyc - acc_cyc, ack_err);
  endtask

  task automatic held_valid_test();
    int L, d0;
    L = 115 * Q + 1;
    @(posedge clk); #1;
    got_ev.delete(); exp_ev.delete();
    slave_nack = 0;
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_dev_addr = 7'h28; cmd_reg_addr = 8'hAA; cmd_data = 8'h55;
    build_txn(7'h28, 8'hAA, 8'h55, 0);
    acc_cyc = cyc;
    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clk); #1;
      if (k <= L) randomize_payload();
    end
    chk("held_a_latency", last_done_cyc - acc_cyc, 461);
    cmd_dev_addr = 7'h16; cmd_reg_addr = 8'h0F; cmd_data = 8'hF0;
    build_txn(7'h16, 8'h0F, 8'hF0, 0);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    randomize_payload();
    wait_drain("held_drain");
    chk("held_b_latency", last_done_cyc - acc_cyc, 461);
    chk("held_done_count", done_cnt - d0, 2);
    check_events("held");
    $display("[TB] txn held_valid two back-to-back commands, events=%0d", got_ev.size());
  endtask

  task automatic reset_mid_test();
    int d0;
    @(posedge clk); #1;
    got_ev.delete(); exp_ev.delete();
    slave_nack = 0;
    cmd_valid = 1'b1; cmd_dev_addr = 7'h39; cmd_reg_addr = 8'h41; cmd_data = 8'h10;
    build_txn(7'h39, 8'h41, 8'h10, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (189) @(posedge clk);
    #1;
    // Third bit of the register byte, first quarter: SCL held low.
    suspend = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    chk("pre_rst_scl", {31'b0, scl_oe}, 32'h1);
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_ready_low", {31'b0, cmd_ready}, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_outputs", {28'b0, scl_oe, sda_oe, busy, done}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", {31'b0, cmd_ready}, 32'h1);
    suspend = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt - d0, 0);
    exp_ev.delete();
    exp_ev.push_back(256);
    exp_ev.push_back(32'h72);
    check_events("rst_mid");
    $display("[TB] txn reset_mid aborted in register byte, events=%0d", got_ev.size());
  endtask

  initial begin
    int d0;
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_dev_addr = '0; cmd_reg_addr = '0; cmd_data = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, cmd_ready}, 32'h0);
    chk("rst_outputs", {27'b0, scl_oe, sda_oe, busy, done, ack_err}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    suspend = 1'b0;
    chk("ready_after_rst", {31'b0, cmd_ready}, 32'h1);
    d0 = done_cnt;
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_no_done", done_cnt - d0, 0);
    $display("[TB] txn idle_after_reset 1000 cycles");

    run_txn(7'h39, 8'h41, 8'h10, 0, 461, "ack_all");
    run_txn(7'h39, 8'h41, 8'h10, 1, 173, "nack_addr");
    run_txn(7'h39, 8'h41, 8'h10, 2, 317, "nack_reg");
    run_txn(7'h39, 8'h41, 8'h10, 3, 461, "nack_data");
    held_valid_test();
    reset_mid_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d failed of %0d", fails, tests);
    $fatal(1, "timeout");
  end

endmodule
